spi_slave_ctrl: RTL

SPI slave front end feeding the single-port RAM command stage. It deserialises 10-bit command words from MOSI while SS_n is low and presents each word as `rx_data` with a one-cycle `rx_valid` strobe. It also captures the RAM's read byte (`tx_data` / `tx_valid`) and serialises it MSB-first onto MISO. The block operates in the system clock domain, and SPI bits are sampled on `clk` rising edges, one bit per cycle.

---
 rtl/spi_slave_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl
//   SPI slave front end for the single-port RAM command stage. While SS_n is
//   low it deserialises one (TX_WIDTH+2)-bit command word from MOSI (one bit
//   per clk, MSB first) and presents it on rx_data with a one-cycle rx_valid
//   strobe. In a read-data frame it latches the RAM's read byte on tx_valid
//   and shifts it out on MISO, MSB first.
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   MOSI      in   serial data in
//   SS_n      in   slave select, active-low; high forces IDLE
//   tx_data   in   [TX_WIDTH-1:0] read byte from the RAM
//   tx_valid  in   strobe qualifying tx_data
//   rx_data   out  [TX_WIDTH+1:0] last complete word, top two bits = command
//   rx_valid  out  one-cycle strobe, rx_data is new
//   MISO      out  serial data out, 0 when not transmitting
module spi_slave_ctrl #(
  parameter int TX_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                MOSI,
  input  logic                SS_n,
  input  logic [TX_WIDTH-1:0] tx_data,
  input  logic                tx_valid,
  output logic [TX_WIDTH+1:0] rx_data,
  output logic                rx_valid,
  output logic                MISO
);

  localparam int RX_W  = TX_WIDTH + 2;
  localparam int RXC_W = $clog2(RX_W + 1);
  localparam int TXC_W = (TX_WIDTH > 1) ? $clog2(TX_WIDTH) : 1;

  localparam logic [RXC_W-1:0] RX_ONE  = RXC_W'(1);
  localparam logic [RXC_W-1:0] RX_LAST = RXC_W'(RX_W - 1);
  localparam logic [RXC_W-1:0] RX_FULL = RXC_W'(RX_W);
  localparam logic [TXC_W-1:0] TX_TOP  = TXC_W'(TX_WIDTH - 1);
  localparam logic [TXC_W-1:0] TX_ZERO = TXC_W'(0);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_e;

  state_e              state_q,    state_d;
  logic [RXC_W-1:0]    rx_cnt_q,   rx_cnt_d;
  logic [RX_W-1:0]     rx_shift_q, rx_shift_d;
  logic [RX_W-1:0]     rx_data_q,  rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rd_seen_q,  rd_seen_d;
  logic [TXC_W-1:0]    tx_cnt_q,   tx_cnt_d;
  logic [TX_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                tx_busy_q,  tx_busy_d;
  logic                miso_q,     miso_d;

  // Next-state logic for the frame FSM, the RX deserialiser and the TX serialiser.
  always_comb begin
    state_d    = state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rd_seen_d  = rd_seen_q;
    tx_cnt_d   = tx_cnt_q;
    tx_shift_d = tx_shift_q;
    tx_busy_d  = tx_busy_q;

    if ((state_q != IDLE) && SS_n) begin
      // Deselect mid-frame: drop any partial word and stop transmitting.
      state_d   = IDLE;
      rx_cnt_d  = '0;
      tx_busy_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rx_cnt_d = '0;
          if (!SS_n) begin
            state_d = CHK_CMD;
          end else begin
            state_d = IDLE;
          end
        end

        CHK_CMD: begin
          rx_shift_d         = '0;
          rx_shift_d[RX_W-1] = MOSI;
          rx_cnt_d           = RX_ONE;
          if (!MOSI) begin
            state_d = WRITE;
          end else if (rd_seen_q) begin
            state_d = READ_DATA;
          end else begin
            state_d = READ_ADD;
          end
        end

        WRITE, READ_ADD, READ_DATA: begin
          // Bits beyond a full word are ignored until the master deselects.
          if (rx_cnt_q != RX_FULL) begin
            rx_shift_d[RX_LAST - rx_cnt_q] = MOSI;
            rx_cnt_d = rx_cnt_q + RX_ONE;
            if (rx_cnt_q == RX_LAST) begin
              rx_data_d  = rx_shift_d;
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD) begin
                rd_seen_d = 1'b1;
              end else if (state_q == READ_DATA) begin
                rd_seen_d = 1'b0;
              end else begin
                rd_seen_d = rd_seen_q;
              end
            end else begin
              rx_valid_d = 1'b0;
            end
          end else begin
            rx_cnt_d = rx_cnt_q;
          end

          // TX runs independently of RX; a new byte is only accepted when idle.
          if (tx_busy_q) begin
            if (tx_cnt_q == TX_ZERO) begin
              tx_busy_d = 1'b0;
            end else begin
              tx_cnt_d = tx_cnt_q - TXC_W'(1);
            end
          end else if (tx_valid && (state_q == READ_DATA)) begin
            tx_shift_d = tx_data;
            tx_cnt_d   = TX_TOP;
            tx_busy_d  = 1'b1;
          end else begin
            tx_busy_d = 1'b0;
          end
        end

        default: begin
          state_d   = IDLE;
          tx_busy_d = 1'b0;
        end
      endcase
    end

    // MISO is registered, so it is computed from the next TX state.
    if (tx_busy_d) begin
      miso_d = tx_shift_d[tx_cnt_d];
    end else begin
      miso_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rx_cnt_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rd_seen_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_shift_q <= '0;
      tx_busy_q  <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rd_seen_q  <= rd_seen_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_shift_q <= tx_shift_d;
      tx_busy_q  <= tx_busy_d;
      miso_q     <= miso_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign MISO     = miso_q;

endmodule
